shadow_preset_register_bank: RTL

- Parametrised successor to the single-bank sync-preset register.
- Holds NUM_REGS channels of WIDTH bits. Each channel has a shadow (staging) copy and an active copy, per-channel synchronous preset to a per-channel preset value, byte-enabled writes, a write lock, and an atomic commit of staged values to active outputs.
- Sits between a config/write interface and datapath logic that needs glitch-free, simultaneously updated control words.

---
 rtl/shadow_preset_register_bank_pkg.sv | 37 +++
 rtl/shadow_preset_register_bank_slice.sv | 75 +++++++
 rtl/shadow_preset_register_bank.sv | 107 ++++++++++
 3 files changed

// File: rtl/shadow_preset_register_bank_pkg.sv
// Shared types and helpers for the shadow/active preset register bank.
// Holds the load-source select, the width derivations and the byte-merge function.
package shadow_preset_pkg;

  typedef enum logic [1:0] {
    LD_NONE   = 2'd0,
    LD_RST    = 2'd1,
    LD_PRESET = 2'd2,
    LD_COMMIT = 2'd3
  } ld_src_e;

  // Widest register the merge helper handles; callers zero-extend into it.
  localparam int MAX_W  = 256;
  localparam int MAX_BE = MAX_W / 8;

  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_be_w(input int w);
    return w / 8;
  endfunction

  function automatic logic [MAX_W-1:0] merge_bytes(
    input logic [MAX_W-1:0]  old_val,
    input logic [MAX_W-1:0]  new_val,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_W-1:0] res;
    res = old_val;
    for (int k = 0; k < MAX_BE; k++) begin
      if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/shadow_preset_register_bank_slice.sv
// One channel: shadow (staging) copy, active copy, pending flag and updated pulse.
// Load source and write qualification come from the bank-level decoder.
module preset_reg_slice
  import shadow_preset_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  ld_src_e            ld_src,
  input  logic               wr_accept,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  output logic [WIDTH-1:0]   active,
  output logic               pending,
  output logic               updated
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pending_q, pending_d;
  logic             updated_q, updated_d;

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    updated_d = 1'b0;
    case (ld_src)
      LD_RST: begin
        shadow_d  = RESET_VAL;
        active_d  = RESET_VAL;
        pending_d = 1'b0;
      end
      LD_PRESET: begin
        shadow_d  = PRESET_VAL;
        active_d  = PRESET_VAL;
        pending_d = 1'b0;
        updated_d = 1'b1;
      end
      LD_COMMIT: begin
        active_d  = shadow_q;
        pending_d = 1'b0;
        updated_d = 1'b1;
      end
      default: ;
    endcase
    // A write landing on a commit edge stages new data after active took the old shadow.
    if (wr_accept && (ld_src == LD_NONE || ld_src == LD_COMMIT)) begin
      shadow_d  = WIDTH'(merge_bytes(MAX_W'(shadow_q), MAX_W'(wr_data), MAX_BE'(wr_be)));
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= RESET_VAL;
      active_q  <= RESET_VAL;
      pending_q <= 1'b0;
      updated_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      updated_q <= updated_d;
    end
  end

  assign active  = active_q;
  assign pending = pending_q;
  assign updated = updated_q;

endmodule

// File: rtl/shadow_preset_register_bank.sv
// Bank of NUM_REGS shadow/active channels with byte-enabled staged writes,
// write lock, per-channel preset, sync clear and atomic commit.
module shadow_preset_register_bank
  import shadow_preset_pkg::*;
#(
  parameter int                        WIDTH      = 32,
  parameter int                        NUM_REGS   = 4,
  parameter logic [WIDTH-1:0]          RESET_VAL  = '0,
  parameter logic [NUM_REGS*WIDTH-1:0] PRESET_VAL = '1,
  localparam int                       AW         = calc_aw(NUM_REGS),
  localparam int                       BE_W       = calc_be_w(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [BE_W-1:0]           wr_be,
  output logic                      wr_err,
  input  logic                      lock,
  input  logic                      commit,
  input  logic                      sync_rst,
  input  logic [NUM_REGS-1:0]       sync_preset,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*WIDTH-1:0] active_out,
  output logic [NUM_REGS-1:0]       pending,
  output logic [NUM_REGS-1:0]       updated
);

  logic [WIDTH-1:0]    active [NUM_REGS];
  ld_src_e             ld_src [NUM_REGS];
  logic [NUM_REGS-1:0] wr_acc;
  logic                wr_in_range;
  logic                wr_hit_preset;
  logic                wr_ok;
  logic                wr_err_q, wr_err_d;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic [WIDTH-1:0]    rd_sel;

  always_comb begin
    wr_in_range   = (int'(wr_addr) < NUM_REGS);
    wr_hit_preset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_addr == AW'(i) && sync_preset[i]) wr_hit_preset = 1'b1;
    end
    wr_ok    = wr_en && !lock && wr_in_range && !sync_rst && !wr_hit_preset;
    wr_err_d = wr_en && !sync_rst && (lock || !wr_in_range);
  end

  always_comb begin
    wr_acc = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sync_rst)                    ld_src[i] = LD_RST;
      else if (sync_preset[i])         ld_src[i] = LD_PRESET;
      else if (commit && pending[i])   ld_src[i] = LD_COMMIT;
      else                             ld_src[i] = LD_NONE;
      wr_acc[i] = wr_ok && (wr_addr == AW'(i));
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_slice
      preset_reg_slice #(
        .WIDTH      (WIDTH),
        .RESET_VAL  (RESET_VAL),
        .PRESET_VAL (PRESET_VAL[g*WIDTH +: WIDTH])
      ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_src    (ld_src[g]),
        .wr_accept (wr_acc[g]),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .active    (active[g]),
        .pending   (pending[g]),
        .updated   (updated[g])
      );
      assign active_out[g*WIDTH +: WIDTH] = active[g];
    end
  endgenerate

  // Out-of-range read addresses fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == AW'(i)) rd_sel = active[i];
    end
    rd_data_d = rd_en ? rd_sel : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_err_q  <= wr_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign wr_err  = wr_err_q;
  assign rd_data = rd_data_q;

endmodule
